// File: rtl/cpu_pkg.sv
// Shared types and constants for the 4-bit CPU fetch/decode/execute sequencer.
package cpu_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StOpfetch,
        StExec,
        StHalted
    } seq_state_e;

    // Unconditional jump opcode; conditional jumps sit above it (13..15)
    localparam logic [3:0] OP_JMP          = 4'hC;
    // Default halt opcode: an all-zero (unprogrammed) ROM byte stops the core
    localparam logic [3:0] OP_HALT_DEFAULT = 4'h0;

    // Instruction byte field slices
    function automatic logic [3:0] ir_opcode(input logic [7:0] ir);
        return ir[7:4];
    endfunction

    function automatic logic [3:0] ir_short(input logic [7:0] ir);
        return ir[3:0];
    endfunction

endpackage

// File: rtl/cpu_pc_reg.sv
// Program counter register: load, +1 or +2, silent modulo-2^PcWidth wrap.
module cpu_pc_reg #(
    parameter int unsigned        PcWidth = 8,
    parameter logic [PcWidth-1:0] ResetPc = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [PcWidth-1:0] load_val_i,
    input  logic               inc1_i,
    input  logic               inc2_i,
    output logic [PcWidth-1:0] pc_o
);

    logic [PcWidth-1:0] pc_q, pc_d;

    // Next PC: load beats +2 beats +1; addition wraps naturally
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc2_i) begin
            pc_d = pc_q + PcWidth'(2);
        end else if (inc1_i) begin
            pc_d = pc_q + PcWidth'(1);
        end
    end

    // PC state with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= ResetPc;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer: memory handshake, IR, operand byte and PC control.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned         PC_WIDTH = 8,
    parameter logic [3:0]          HALT_OP  = OP_HALT_DEFAULT,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic                MemAck,
    input  logic [7:0]          MemData,
    output logic                MemReq,
    output logic [PC_WIDTH-1:0] MemAddr,
    output logic [3:0]          Op,
    output logic                Bit,
    input  logic                IsAddress,
    input  logic                IsJump,
    input  logic                CondFlag,
    output logic [3:0]          ShortOpnd,
    output logic [7:0]          LongOpnd,
    output logic [PC_WIDTH-1:0] Pc,
    output logic                Busy,
    output logic                Halted
);

    seq_state_e          state_q, state_d;
    logic [7:0]          ir_q, ir_d;
    logic [7:0]          long_opnd_q, long_opnd_d;
    logic                pc_load, pc_inc1, pc_inc2;
    logic [PC_WIDTH-1:0] jump_target;
    logic                two_word;
    logic                jump_taken;

    assign two_word    = IsAddress | IsJump;
    assign jump_taken  = IsJump & ((ir_opcode(ir_q) == OP_JMP) | CondFlag);
    // Operand byte is zero-extended or truncated to the PC width
    assign jump_target = PC_WIDTH'(long_opnd_q);

    cpu_pc_reg #(
        .PcWidth (PC_WIDTH),
        .ResetPc (RESET_PC)
    ) u_pc_reg (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .load_i     (pc_load),
        .load_val_i (jump_target),
        .inc1_i     (pc_inc1),
        .inc2_i     (pc_inc2),
        .pc_o       (Pc)
    );

    // Next-state, IR/operand capture and PC update requests
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        long_opnd_d = long_opnd_q;
        pc_load     = 1'b0;
        pc_inc1     = 1'b0;
        pc_inc2     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Start) state_d = StFetch;
            end
            StHalted: begin
                // Resume past the halt instruction
                if (Start) begin
                    state_d = StFetch;
                    pc_inc1 = 1'b1;
                end
            end
            StFetch: begin
                if (MemAck) begin
                    ir_d    = MemData;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (ir_opcode(ir_q) == HALT_OP) begin
                    state_d = StHalted;
                end else if (two_word) begin
                    state_d = StOpfetch;
                end else begin
                    state_d = StExec;
                end
            end
            StOpfetch: begin
                if (MemAck) begin
                    long_opnd_d = MemData;
                    state_d     = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                if (jump_taken) begin
                    pc_load = 1'b1;
                end else if (two_word) begin
                    pc_inc2 = 1'b1;
                end else begin
                    pc_inc1 = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, IR and operand registers; reset clears everything
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= StIdle;
            ir_q        <= '0;
            long_opnd_q <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            long_opnd_q <= long_opnd_d;
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        MemReq  = 1'b0;
        MemAddr = '0;
        Bit     = 1'b0;
        Busy    = 1'b1;
        Halted  = 1'b0;
        unique case (state_q)
            StFetch: begin
                MemReq  = 1'b1;
                MemAddr = Pc;
            end
            StOpfetch: begin
                MemReq  = 1'b1;
                MemAddr = Pc + PC_WIDTH'(1);
            end
            StExec:   Bit  = 1'b1;
            StIdle:   Busy = 1'b0;
            StHalted: begin
                Busy   = 1'b0;
                Halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign Op        = ir_opcode(ir_q);
    assign ShortOpnd = ir_short(ir_q);
    assign LongOpnd  = long_opnd_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer with a ROM/handshake model.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, mem_ack, mem_req, bit_o, busy, halted;
    logic       is_address, is_jump, cond_flag, stray_ack;
    logic [7:0] mem_data, mem_addr, long_opnd, pc;
    logic [3:0] op, short_opnd;
    logic [7:0] rom [256];
    int         ack_delay = 0;
    int         wait_cnt  = 0;
    int         checks    = 0;
    int         errors    = 0;
    int         bit_cnt   = 0;
    int         n;
    logic       found;

    always #5 clk = ~clk;

    // Memory answers after ack_delay cycles of a held request
    assign mem_ack    = (mem_req && (wait_cnt >= ack_delay)) || stray_ack;
    assign mem_data   = rom[mem_addr];
    // Toy decoder: 8 is an address-class op, 12..15 are jumps
    assign is_jump    = (op >= 4'hC);
    assign is_address = (op == 4'h8);

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    cpu_sequencer #(
        .PC_WIDTH (8),
        .HALT_OP  (4'h0),
        .RESET_PC (8'h00)
    ) dut (
        .Clock     (clk),
        .Reset     (rst),
        .Start     (start),
        .MemAck    (mem_ack),
        .MemData   (mem_data),
        .MemReq    (mem_req),
        .MemAddr   (mem_addr),
        .Op        (op),
        .Bit       (bit_o),
        .IsAddress (is_address),
        .IsJump    (is_jump),
        .CondFlag  (cond_flag),
        .ShortOpnd (short_opnd),
        .LongOpnd  (long_opnd),
        .Pc        (pc),
        .Busy      (busy),
        .Halted    (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and sample 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        if (bit_o) bit_cnt++;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        start     = 1'b0;
        stray_ack = 1'b0;
        cond_flag = 1'b0;
        ack_delay = 0;
        step();
        step();
        rst     = 1'b0;
        bit_cnt = 0;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Step until Bit is seen; steps taken go to cycles
    task automatic run_to_bit(input int max, output int cycles);
        logic seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < max && !seen; i++) begin
            step();
            cycles++;
            if (bit_o) seen = 1'b1;
        end
        check("bit_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stray_ack = 1'b0; cond_flag = 1'b0;
        clear_rom();

        // Reset state
        do_reset();
        check("rst_req", 32'(mem_req), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_op", 32'(op), 0);
        check("rst_bit", 32'(bit_o), 0);
        check("rst_long", 32'(long_opnd), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);

        // MemAck outside a request is ignored
        stray_ack = 1'b1;
        step();
        step();
        stray_ack = 1'b0;
        check("stray_busy", 32'(busy), 0);
        check("stray_op", 32'(op), 0);

        // One-word op 0x15
        rom[0] = 8'h15;
        kick();
        check("w1_req", 32'(mem_req), 1);
        check("w1_addr", 32'(mem_addr), 0);
        check("w1_busy", 32'(busy), 1);
        step();
        check("w1_dec_op", 32'(op), 4'h1);
        check("w1_dec_short", 32'(short_opnd), 4'h5);
        check("w1_dec_bit", 32'(bit_o), 0);
        step();
        check("w1_exec_bit", 32'(bit_o), 1);
        step();
        check("w1_pc", 32'(pc), 8'h01);
        check("w1_next_addr", 32'(mem_addr), 8'h01);
        check("w1_bit_cnt", 32'(bit_cnt), 1);

        // Unconditional jump C0 20
        clear_rom();
        rom[0] = 8'hC0; rom[1] = 8'h20;
        do_reset();
        kick();
        step();
        step();
        check("jmp_opf_addr", 32'(mem_addr), 8'h01);
        check("jmp_opf_req", 32'(mem_req), 1);
        step();
        check("jmp_exec_bit", 32'(bit_o), 1);
        check("jmp_long", 32'(long_opnd), 8'h20);
        step();
        check("jmp_pc", 32'(pc), 8'h20);
        check("jmp_addr", 32'(mem_addr), 8'h20);

        // Conditional jump D0 40, flag clear then set
        for (int f = 0; f < 2; f++) begin
            clear_rom();
            rom[0] = 8'hD0; rom[1] = 8'h40;
            do_reset();
            cond_flag = (f == 1);
            kick();
            run_to_bit(10, n);
            check("cj_latency", 32'(n), 3);
            step();
            check(f == 1 ? "cj_taken_pc" : "cj_not_taken_pc", 32'(pc), f == 1 ? 8'h40 : 8'h02);
        end
        cond_flag = 1'b0;

        // Address-class op 0x83 0x99 steps PC by 2
        clear_rom();
        rom[0] = 8'h83; rom[1] = 8'h99;
        do_reset();
        kick();
        run_to_bit(10, n);
        check("addr_long", 32'(long_opnd), 8'h99);
        step();
        check("addr_pc", 32'(pc), 8'h02);

        // Three wait states in FETCH
        clear_rom();
        rom[0] = 8'h15;
        do_reset();
        ack_delay = 3;
        kick();
        for (int i = 0; i < 3; i++) begin
            check("wait_req", 32'(mem_req), 1);
            check("wait_addr", 32'(mem_addr), 0);
            check("wait_ack", 32'(mem_ack), 0);
            step();
        end
        check("wait_ack_cycle", 32'(mem_ack), 1);
        check("wait_ir_hold", 32'(op), 0);
        step();
        check("wait_ir_load", 32'(op), 4'h1);
        check("wait_req_drop", 32'(mem_req), 0);
        ack_delay = 0;

        // Halt at ROM[5]
        clear_rom();
        for (int i = 0; i < 5; i++) rom[i] = 8'h15;
        do_reset();
        kick();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (halted) found = 1'b1;
        end
        check("halt_seen", 32'(found), 1);
        check("halt_busy", 32'(busy), 0);
        check("halt_pc", 32'(pc), 8'h05);
        check("halt_bits", 32'(bit_cnt), 5);
        kick();
        check("resume_addr", 32'(mem_addr), 8'h06);
        check("resume_halted", 32'(halted), 0);

        // PC wrap from 0xFF
        clear_rom();
        rom[0] = 8'hC0; rom[1] = 8'hFF; rom[8'hFF] = 8'h15;
        do_reset();
        kick();
        run_to_bit(10, n);
        step();
        check("wrap_fetch_addr", 32'(mem_addr), 8'hFF);
        run_to_bit(10, n);
        step();
        check("wrap_pc", 32'(pc), 8'h00);
        check("wrap_addr", 32'(mem_addr), 8'h00);

        // Reset during OPFETCH
        clear_rom();
        rom[0] = 8'hC0; rom[1] = 8'h33;
        do_reset();
        ack_delay = 4;
        kick();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (mem_req && mem_addr == 8'h01 && op == 4'hC) found = 1'b1;
        end
        check("opf_reached", 32'(found), 1);
        rst = 1'b1;
        step();
        check("opf_rst_req", 32'(mem_req), 0);
        check("opf_rst_pc", 32'(pc), 0);
        check("opf_rst_busy", 32'(busy), 0);
        check("opf_rst_long", 32'(long_opnd), 0);
        rst = 1'b0;
        ack_delay = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
